// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory stage of a pipelined core.
// A word-addressed store is accessed after LATENCY stall cycles; mem_stall holds
// the pipeline until the access completes, and read data appears in the
// completion (DONE) cycle. LATENCY=0 degenerates to a plain single-cycle memory.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdata,
  output logic        mem_stall,
  output logic        misalign
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam bit          Lat0    = (LATENCY == 0);
  localparam bit          Lat1    = (LATENCY == 1);
  // WAIT counts down to zero, so it is loaded two short of the stall length.
  localparam logic [3:0]  CntInit = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            req;
  logic            aligned;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word;
  logic            perform;
  logic            mem_we;
  logic            unused_addr_hi;

  assign req     = memreadM | memwriteM;
  assign aligned = (aluoutM[1:0] == 2'b00);
  // Address bits above the store size are ignored, so accesses wrap.
  assign idx            = aluoutM[IdxW+1:2];
  assign unused_addr_hi = ^aluoutM[31:IdxW+2];
  assign rd_word        = mem_q[idx];

  // Misaligned stores are dropped; a write is also blocked while reset is low.
  assign mem_we = reset & memwriteM & aligned & (Lat0 ? 1'b1 : perform);

  // Backing store: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= writedataM;
    end
  end

  // State, countdown and captured-result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state: start on request, count down in WAIT, abort on a flush, access on expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perform = 1'b0;
    if (!Lat0) begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (Lat1) begin
              perform = 1'b1;
              state_d = StDone;
            end else begin
              cnt_d   = CntInit;
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_d = StIdle;
          end else if (cnt_q == 4'd0) begin
            perform = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // The pre-write word is captured, so a combined read+write returns old data.
    rdata_d    = perform ? rd_word : rdata_q;
    misalign_d = perform ? ~aligned : misalign_q;
  end

  // Outputs: stall while an access is outstanding, result shown in DONE.
  always_comb begin
    mem_stall = 1'b0;
    misalign  = 1'b0;
    readdata  = rdata_q;
    if (Lat0) begin
      readdata = reset ? rd_word : 32'd0;
      misalign = reset & req & ~aligned;
    end else begin
      mem_stall = reset & (((state_q == StIdle) & req) | (state_q == StWait));
      misalign  = reset & (state_q == StDone) & misalign_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance checked every cycle against a
// transaction-level model, a LATENCY=0 instance sharing its inputs and checked
// against a plain array model, and a LATENCY=3 instance exercised by directed flushes.
module tb_dmem_responder;

  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        rd_i = 1'b0, wr_i = 1'b0;
  logic [31:0] addr_i = 32'd0, wd_i = 32'd0;
  logic        rd3 = 1'b0, wr3 = 1'b0;
  logic [31:0] a3 = 32'd0, d3 = 32'd0;

  logic [31:0] readdata, readdata0, readdata3;
  logic        stall, stall0, stall3, mis, mis0, mis3;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(Lat)) u_dut (
    .clk(clk), .reset(reset), .memreadM(rd_i), .memwriteM(wr_i), .aluoutM(addr_i),
    .writedataM(wd_i), .readdata(readdata), .mem_stall(stall), .misalign(mis)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .memreadM(rd_i), .memwriteM(wr_i), .aluoutM(addr_i),
    .writedataM(wd_i), .readdata(readdata0), .mem_stall(stall0), .misalign(mis0)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .memreadM(rd3), .memwriteM(wr3), .aluoutM(a3),
    .writedataM(d3), .readdata(readdata3), .mem_stall(stall3), .misalign(mis3)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Transaction-level model of the LATENCY=2 instance: a request first seen at
  // cycle s (outside a DONE cycle) stalls cycles s..s+Lat-1, commits at the end
  // of s+Lat-1 and shows its result in cycle s+Lat. Dropping it early cancels it.
  int          cyc = 0;
  bit          act = 1'b0;
  int          start = 0;
  int          done_at = -1;
  logic [31:0] rd_m = 32'd0;
  bit          rd_known = 1'b1;
  bit          mis_m = 1'b0;
  logic [31:0] mem2 [int];
  logic [31:0] mem0 [int];

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      act      = 1'b0;
      done_at  = -1;
      rd_m     = 32'd0;
      rd_known = 1'b1;
      mis_m    = 1'b0;
    end else begin
      if (wr_i && addr_i[1:0] == 2'b00) mem0[widx(addr_i)] = wd_i;
      if (!act && (rd_i || wr_i) && cyc != done_at) begin
        act   = 1'b1;
        start = cyc;
      end
      if (act) begin
        if (!(rd_i || wr_i)) begin
          act = 1'b0;
        end else if (cyc - start == int'(Lat) - 1) begin
          rd_known = mem2.exists(widx(addr_i));
          rd_m     = rd_known ? mem2[widx(addr_i)] : 32'd0;
          mis_m    = (addr_i[1:0] != 2'b00);
          if (wr_i && !mis_m) mem2[widx(addr_i)] = wd_i;
          act     = 1'b0;
          done_at = cyc + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both model-tracked instances.
  logic creq;
  logic e_st, e_mis;
  initial forever begin
    @(negedge clk);
    creq  = rd_i | wr_i;
    e_st  = reset && (act || (cyc != done_at && creq));
    e_mis = reset && !act && (cyc == done_at) && mis_m;
    check("stall", {31'd0, stall}, {31'd0, e_st});
    check("misalign", {31'd0, mis}, {31'd0, e_mis});
    if (rd_known) check("readdata", readdata, rd_m);
    check("l0_stall", {31'd0, stall0}, 32'd0);
    check("l0_misalign", {31'd0, mis0}, {31'd0, reset && creq && addr_i[1:0] != 2'b00});
    if (!reset) check("l0_readdata_reset", readdata0, 32'd0);
    else if (mem0.exists(widx(addr_i))) check("l0_readdata", readdata0, mem0[widx(addr_i)]);
  end

  // One access on the LATENCY=2 port, request held for 'hold' cycles.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold, output logic [3:0] stv,
                        output logic [31:0] rdo, output logic miso, output logic [31:0] rd0);
    stv = 4'd0; rdo = 32'd0; miso = 1'b0; rd0 = 32'd0;
    rd_i = r; wr_i = w; addr_i = a; wd_i = d;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k < 4) stv[k] = stall;
      if (k == int'(Lat)) begin
        rdo  = readdata;
        miso = mis;
      end
      if (k == 0) rd0 = readdata0;
      @(posedge clk); #1;
    end
    rd_i = 1'b0; wr_i = 1'b0;
  endtask

  // One access on the LATENCY=3 port; request dropped after reqcyc of total cycles.
  task automatic access3(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int reqcyc, input int total,
                         output logic [3:0] stv, output logic [31:0] rdo, output logic miso);
    stv = 4'd0; rdo = 32'd0; miso = 1'b0;
    rd3 = r; wr3 = w; a3 = a; d3 = d;
    for (int k = 0; k < total; k++) begin
      if (k == reqcyc) begin
        rd3 = 1'b0; wr3 = 1'b0;
      end
      @(negedge clk);
      if (k < 4) stv[k] = stall3;
      if (k == 3) begin
        rdo  = readdata3;
        miso = mis3;
      end
      @(posedge clk); #1;
    end
    rd3 = 1'b0; wr3 = 1'b0;
  endtask

  logic [3:0]  stv;
  logic [31:0] rdo, rd0, a;
  logic        miso;
  logic [1:0]  lo;
  int          op, hold, gap, word;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", {29'd0, stall, stall0, stall3}, 32'd0);
    check("rst_misalign", {29'd0, mis, mis0, mis3}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_readdata3", readdata3, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 3, stv, rdo, miso, rd0);

    // Write then read at 0x10: two stall cycles, data in the third.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, stv, rdo, miso, rd0);
    check("wr_stall_pattern", {28'd0, stv}, 32'b011);
    access(1'b1, 1'b0, 32'h10, 32'h0, 3, stv, rdo, miso, rd0);
    check("rd_stall_pattern", {28'd0, stv}, 32'b011);
    check("rd_0x10", rdo, 32'hDEADBEEF);

    // Address wrap.
    access(1'b0, 1'b1, 32'h400, 32'h12345678, 3, stv, rdo, miso, rd0);
    access(1'b1, 1'b0, 32'h000, 32'h0, 3, stv, rdo, miso, rd0);
    check("wrap_read", rdo, 32'h12345678);

    // Misaligned store is suppressed and flagged.
    access(1'b0, 1'b1, 32'h20, 32'h11111111, 3, stv, rdo, miso, rd0);
    access(1'b0, 1'b1, 32'h22, 32'hAAAAAAAA, 3, stv, rdo, miso, rd0);
    check("misalign_flag", {31'd0, miso}, 32'd1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 3, stv, rdo, miso, rd0);
    check("misalign_nowrite", rdo, 32'h11111111);
    check("aligned_noflag", {31'd0, miso}, 32'd0);

    // Combined read+write returns the old word.
    access(1'b0, 1'b1, 32'h8, 32'h5, 3, stv, rdo, miso, rd0);
    access(1'b1, 1'b1, 32'h8, 32'h9, 3, stv, rdo, miso, rd0);
    check("rw_old_word", rdo, 32'h5);
    access(1'b1, 1'b0, 32'h8, 32'h0, 3, stv, rdo, miso, rd0);
    check("rw_new_word", rdo, 32'h9);

    // Zero-latency instance: data visible in the request cycle.
    access(1'b0, 1'b1, 32'h4, 32'hC0FFEE00, 3, stv, rdo, miso, rd0);
    access(1'b1, 1'b0, 32'h4, 32'h0, 3, stv, rdo, miso, rd0);
    check("l0_same_cycle", rd0, 32'hC0FFEE00);

    // Reset during WAIT drops the pending write to word 5.
    access(1'b0, 1'b1, 32'h14, 32'h55, 3, stv, rdo, miso, rd0);
    wr_i = 1'b1; addr_i = 32'h14; wd_i = 32'h00000BAD;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_stall", {31'd0, stall}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_readdata", readdata, 32'd0);
    check("async_rst_misalign", {31'd0, mis}, 32'd0);
    @(posedge clk); #1;
    wr_i = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h14, 32'h0, 3, stv, rdo, miso, rd0);
    check("rst_dropped_write", rdo, 32'h55);

    // LATENCY=3: full write, flushed write, then read back the first value.
    access3(1'b0, 1'b1, 32'h30, 32'h77, 4, 4, stv, rdo, miso);
    check("l3_stall_pattern", {28'd0, stv}, 32'b0111);
    access3(1'b0, 1'b1, 32'h30, 32'h99, 2, 4, stv, rdo, miso);
    check("l3_flush_pattern", {28'd0, stv}, 32'b0111);
    access3(1'b1, 1'b0, 32'h30, 32'h0, 4, 4, stv, rdo, miso);
    check("l3_flush_nowrite", rdo, 32'h77);
    check("l3_misalign", {31'd0, miso}, 32'd0);

    // Random traffic with wrap bits, misalignment, combined ops and flushes.
    for (int n = 0; n < 300; n++) begin
      word = $urandom_range(0, 15);
      lo   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a    = ($urandom & 32'hFFFF_FC00) | 32'(word * 4) | {30'd0, lo};
      op   = $urandom_range(0, 2);
      hold = ($urandom_range(0, 7) == 0) ? 1 : int'(Lat) + 1;
      access(op != 1, op != 0, a, $urandom, hold, stv, rdo, miso, rd0);
      gap = $urandom_range(0, 2) + ((hold == 1) ? 1 : 0);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
